efuse_ctrl_banked: RTL and testbench

- Clocked sequencer driving NBANKS eFuse macros, each NWORDS x WORD_WIDTH, through their raw pins (BIT_SEL, COL_PROG_N, PRESET_N, SENSE, OUT).
- Converts single-word read/program requests into correctly timed preset -> sense and per-bit program pulse sequences.
- Programs one fuse bit at a time to bound programming current.
- Sits between the Wishbone slave and the fuse arrays; it generalises the single 64x32 array to banked depth and parametrised width and timing.

---
 rtl/efuse_ctrl_pkg.sv | 38 +++
 rtl/efuse_ctrl_bitscan.sv | 24 ++
 rtl/efuse_ctrl_banked.sv | 202 ++++++++++++++++++++
 tb/tb_efuse_ctrl_banked.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/efuse_ctrl_pkg.sv
// Shared types, default timing and address helpers for the banked eFuse controller.
package efuse_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESET,
    ST_SENSE,
    ST_RELEASE,
    ST_PSETUP,
    ST_PPULSE,
    ST_PGAP,
    ST_RESP
  } state_e;

  localparam int DEF_NBANKS        = 16;
  localparam int DEF_NWORDS        = 64;
  localparam int DEF_WORD_WIDTH    = 32;
  localparam int DEF_PRESET_CYCLES = 1;
  localparam int DEF_SENSE_CYCLES  = 1;
  localparam int DEF_PROG_CYCLES   = 40;

  // Upper address bits pick the bank.
  function automatic int unsigned bank_of(input int unsigned addr, input int unsigned nwords);
    return addr / nwords;
  endfunction

  // Lower address bits pick the word inside the bank.
  function automatic int unsigned word_of(input int unsigned addr, input int unsigned nwords);
    return addr % nwords;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/efuse_ctrl_bitscan.sv
// Lowest-set-bit finder over the remaining program mask.
module efuse_ctrl_bitscan #(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the MSB down so the last hit (the lowest set bit) wins.
  always_comb begin
    // NOTE: both outputs get a default before the loop, so no path infers a latch.
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/efuse_ctrl_banked.sv
// Banked eFuse sequencer: turns single-word read/program requests into timed
// preset/sense and one-bit-at-a-time program pulses on the raw array pins.
// Optional build macro EFUSE_CTRL_VERIFY_EN adds an automatic readback after
// programming and flags bits that did not blow.
module efuse_ctrl_banked
  import efuse_ctrl_pkg::*;
#(
  parameter  int NBANKS        = DEF_NBANKS,
  parameter  int NWORDS        = DEF_NWORDS,
  parameter  int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter  int PRESET_CYCLES = DEF_PRESET_CYCLES,
  parameter  int SENSE_CYCLES  = DEF_SENSE_CYCLES,
  parameter  int PROG_CYCLES   = DEF_PROG_CYCLES,
  localparam int ADDR_W        = $clog2(NBANKS * NWORDS)
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [WORD_WIDTH-1:0]        req_wdata_i,
  input  logic                         prog_en_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [WORD_WIDTH-1:0]        rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic [NBANKS*NWORDS-1:0]     bit_sel_o,
  output logic [NBANKS*WORD_WIDTH-1:0] col_prog_n_o,
  output logic [NBANKS-1:0]            preset_n_o,
  output logic [NBANKS-1:0]            sense_o,
  input  logic [NBANKS*WORD_WIDTH-1:0] array_out_i
);

  localparam int IDX_W   = $clog2(WORD_WIDTH);
  localparam int MAX_CYC = max3(PRESET_CYCLES, SENSE_CYCLES, PROG_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [WORD_WIDTH-1:0] mask_q;
  logic [IDX_W-1:0]      cur_idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [WORD_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  abort_q;
`ifdef EFUSE_CTRL_VERIFY_EN
  logic [WORD_WIDTH-1:0] wdata_q;
  logic                  is_write_q;
`endif

  int unsigned           bank;
  logic [WORD_WIDTH-1:0] bank_out;
  logic [WORD_WIDTH-1:0] scan_in;
  logic [IDX_W-1:0]      scan_idx;
  logic                  scan_any;

  assign bank     = bank_of(32'(addr_q), NWORDS);
  assign bank_out = array_out_i[bank*WORD_WIDTH +: WORD_WIDTH];
  // In IDLE the first bit is picked straight from the incoming request.
  assign scan_in  = (state_q == ST_IDLE) ? req_wdata_i : mask_q;

  efuse_ctrl_bitscan #(.WIDTH(WORD_WIDTH)) u_bitscan (
    .mask (scan_in),
    .idx  (scan_idx),
    .any  (scan_any)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Next-state selection for the read / program sequences.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (!req_write_i)                state_d = ST_PRESET;
          else if (prog_en_i && scan_any)  state_d = ST_PSETUP;
          else                             state_d = ST_RESP;
        end
      end
      ST_PRESET:  if (cnt_q == '0) state_d = ST_SENSE;
      ST_SENSE: begin
        if (cnt_q == '0) begin
`ifdef EFUSE_CTRL_VERIFY_EN
          state_d = is_write_q ? ST_RELEASE : ST_RESP;
`else
          state_d = ST_RESP;
`endif
        end
      end
      ST_RELEASE: state_d = ST_RESP;
      ST_PSETUP:  state_d = ST_PPULSE;
      ST_PPULSE:  if (cnt_q == '0) state_d = ST_PGAP;
      ST_PGAP: begin
        if (abort_q || !prog_en_i) state_d = ST_RESP;
        else if (scan_any)         state_d = ST_PSETUP;
        else begin
`ifdef EFUSE_CTRL_VERIFY_EN
          state_d = ST_PRESET;
`else
          state_d = ST_RESP;
`endif
        end
      end
      ST_RESP:    if (rsp_ready_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, phase counter and request/response registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      cur_idx_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
`ifdef EFUSE_CTRL_VERIFY_EN
      wdata_q    <= '0;
      is_write_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register here sees pre-edge values of the others.
      state_q <= state_d;

      if (state_d != state_q) begin
        unique case (state_d)
          ST_PRESET: cnt_q <= CNT_W'(PRESET_CYCLES - 1);
          ST_SENSE:  cnt_q <= CNT_W'(SENSE_CYCLES - 1);
          ST_PPULSE: cnt_q <= CNT_W'(PROG_CYCLES - 1);
          default:   cnt_q <= '0;
        endcase
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q    <= req_addr_i;
            mask_q    <= req_wdata_i;
            cur_idx_q <= scan_idx;
            rdata_q   <= '0;
            err_q     <= req_write_i && !prog_en_i;
            abort_q   <= 1'b0;
`ifdef EFUSE_CTRL_VERIFY_EN
            wdata_q    <= req_wdata_i;
            is_write_q <= req_write_i;
`endif
          end
        end
        ST_SENSE: begin
          if (cnt_q == '0) begin
            rdata_q <= bank_out;
`ifdef EFUSE_CTRL_VERIFY_EN
            if (is_write_q) err_q <= ((bank_out & wdata_q) != wdata_q);
`endif
          end
        end
        ST_PSETUP: if (!prog_en_i) abort_q <= 1'b1;
        ST_PPULSE: begin
          if (!prog_en_i) abort_q <= 1'b1;
          if (cnt_q == '0) mask_q[cur_idx_q] <= 1'b0;
        end
        ST_PGAP: begin
          cur_idx_q <= scan_idx;
          if (abort_q || !prog_en_i) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Array pins: everything at the safe idle set except the active bank's pins.
  always_comb begin
    bit_sel_o    = '0;
    col_prog_n_o = '1;
    preset_n_o   = '1;
    sense_o      = '0;
    unique case (state_q)
      ST_PRESET: preset_n_o[bank] = 1'b0;
      ST_SENSE: begin
        sense_o[bank]     = 1'b1;
        bit_sel_o[addr_q] = 1'b1;
      end
      ST_PSETUP: bit_sel_o[addr_q] = 1'b1;
      ST_PPULSE: begin
        bit_sel_o[addr_q] = 1'b1;
        col_prog_n_o[bank*WORD_WIDTH + 32'(cur_idx_q)] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_efuse_ctrl_banked.sv
// Randomised self-checking bench for efuse_ctrl_banked with a fuse-array model
// and a transaction-level reference schedule of every pin.
module tb_efuse_ctrl_banked;

  localparam int NB = 16, NW = 64, WW = 32, P = 1, S = 1, PC = 40;
  localparam int NA = NB * NW;
  localparam int AW = $clog2(NA);

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i;
  logic                req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0]       req_addr_i;
  logic [WW-1:0]       req_wdata_i;
  logic                prog_en_i;
  logic                rsp_valid_o, rsp_ready_i;
  logic [WW-1:0]       rsp_rdata_o;
  logic                rsp_err_o;
  logic [NA-1:0]       bit_sel_o;
  logic [NB*WW-1:0]    col_prog_n_o;
  logic [NB-1:0]       preset_n_o;
  logic [NB-1:0]       sense_o;
  logic [NB*WW-1:0]    array_out_i;

  logic [31:0] ref_mem [NA];
  logic [31:0] stuck   [NA];
  logic [31:0] phys    [NA];
  bit          init_done = 1'b0;
  int          blk_sel;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          txn_id   = 0;

  efuse_ctrl_banked #(
    .NBANKS(NB), .NWORDS(NW), .WORD_WIDTH(WW),
    .PRESET_CYCLES(P), .SENSE_CYCLES(S), .PROG_CYCLES(PC)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .prog_en_i    (prog_en_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .bit_sel_o    (bit_sel_o),
    .col_prog_n_o (col_prog_n_o),
    .preset_n_o   (preset_n_o),
    .sense_o      (sense_o),
    .array_out_i  (array_out_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Fuse array model: OUT shows the selected word of a bank while it senses.
  always_comb begin
    array_out_i = '0;
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++)
        if (bit_sel_o[b*NW + w] && sense_o[b]) array_out_i[b*WW +: WW] = phys[b*NW + w];
  end

  // Fuse array model: a low column on the selected word blows that bit (unless stuck).
  always @(posedge wb_clk_i) begin
    if (!init_done) begin
      for (int i = 0; i < NA; i++) phys[i] = ref_mem[i];
      init_done = 1'b1;
    end else begin
      blk_sel = -1;
      for (int i = 0; i < NA; i++) if (bit_sel_o[i]) blk_sel = i;
      if (blk_sel >= 0)
        for (int c = 0; c < WW; c++)
          if (!col_prog_n_o[(blk_sel / NW) * WW + c])
            phys[blk_sel][c] = phys[blk_sel][c] | ~stuck[blk_sel][c];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Summarise a wide vector as {number of set bits, lowest set index}.
  function automatic logic [63:0] enc(input logic [NA-1:0] v);
    int cnt = 0;
    int idx = 0;
    for (int i = NA - 1; i >= 0; i--) if (v[i]) begin cnt++; idx = i; end
    return {32'(cnt), 32'(idx)};
  endfunction

  function automatic logic [63:0] one(input int i);
    return (i < 0) ? 64'd0 : {32'd1, 32'(i)};
  endfunction

  task automatic check_pins(input string pfx, input int bs, input int col,
                            input logic [15:0] pre, input logic [15:0] sen, input logic [1:0] hs);
    check({pfx, " bit_sel"}, enc(bit_sel_o), one(bs));
    check({pfx, " col_prog"}, enc({{(NA-NB*WW){1'b0}}, ~col_prog_n_o}), one(col));
    check({pfx, " preset/sense"}, {32'd0, preset_n_o, sense_o}, {32'd0, pre, sen});
    check({pfx, " ready/valid"}, {62'd0, req_ready_o, rsp_valid_o}, {62'd0, hs});
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!req_ready_o && guard < 200) begin
      @(negedge wb_clk_i);
      guard++;
    end
    check("wait_ready", 64'(req_ready_o), 64'd1);
  endtask

  // One request: the reference schedule is derived from bit positions and
  // phase lengths, then every cycle's pins and the response are compared.
  task automatic run_txn(input bit wr, input int addr, input logic [31:0] wdata,
                         input bit pen, input int drop_at);
    int bits[$];
    int k, keff, lat, rd_start, bank, bs, col, rc, j, off, hold;
    bit aborted, exp_err;
    logic [31:0] exp_rdata, done_mask, newval;
    logic [15:0] pre, sen;
    string tag;

    txn_id++;
    wait_ready();
    bank = addr / NW;
    for (int i = 0; i < WW; i++) if (wdata[i]) bits.push_back(i);
    k = bits.size();
    keff = 0; aborted = 1'b0; exp_err = 1'b0; exp_rdata = '0; rd_start = -1; done_mask = '0;
    if (!wr) begin
      lat = P + S + 1;
      exp_rdata = ref_mem[addr];
      rd_start = 1;
    end else if (!pen) begin
      lat = 1;
      exp_err = 1'b1;
    end else begin
      keff = k;
      if (drop_at > 0 && drop_at <= k * (PC + 2)) begin
        keff = (drop_at - 1) / (PC + 2) + 1;
        aborted = 1'b1;
      end
      for (int i = 0; i < keff; i++) done_mask[bits[i]] = 1'b1;
      newval = ref_mem[addr] | (done_mask & ~stuck[addr]);
      ref_mem[addr] = newval;
      lat = 1 + keff * (PC + 2);
      exp_err = aborted;
`ifdef EFUSE_CTRL_VERIFY_EN
      if (!aborted && k > 0) begin
        rd_start = lat;
        lat += P + S + 1;
        exp_rdata = newval;
        exp_err = ((newval & wdata) != wdata);
      end
`endif
    end

    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = AW'(addr);
    req_wdata_i = wdata; prog_en_i = pen;
    check_pins($sformatf("t%0d c0", txn_id), -1, -1, 16'hFFFF, 16'h0, 2'b10);

    for (int c = 1; c <= lat; c++) begin
      @(negedge wb_clk_i);
      if (c == 1) req_valid_i = 1'b0;
      if (c == drop_at) prog_en_i = 1'b0;
      bs = -1; col = -1; pre = 16'hFFFF; sen = 16'h0;
      if (rd_start > 0 && c >= rd_start) begin
        rc = c - rd_start + 1;
        if (rc <= P) pre[bank] = 1'b0;
        else if (rc <= P + S) begin sen[bank] = 1'b1; bs = addr; end
      end else if (wr && pen) begin
        j = (c - 1) / (PC + 2);
        off = (c - 1) % (PC + 2);
        if (j < keff) begin
          if (off <= PC) bs = addr;
          if (off >= 1 && off <= PC) col = bank * WW + bits[j];
        end
      end
      tag = $sformatf("t%0d c%0d", txn_id, c);
      check_pins(tag, bs, col, pre, sen, {1'b0, c == lat});
    end
    check($sformatf("t%0d rdata", txn_id), 64'(rsp_rdata_o), 64'(exp_rdata));
    check($sformatf("t%0d err", txn_id), 64'(rsp_err_o), 64'(exp_err));

    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge wb_clk_i);
      check($sformatf("t%0d hold", txn_id), {31'd0, rsp_valid_o, rsp_rdata_o}, {31'd0, 1'b1, exp_rdata});
    end
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    prog_en_i = 1'b1;
    check($sformatf("t%0d back_idle", txn_id), {62'd0, req_ready_o, rsp_valid_o}, 64'd2);
  endtask

  task automatic reset_mid_pulse();
    wait_ready();
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = AW'(NA - 1);
    req_wdata_i = 32'h1; prog_en_i = 1'b1;
    @(negedge wb_clk_i);
    req_valid_i = 1'b0;
    repeat (9) @(negedge wb_clk_i);
    check("pulse_before_rst", enc({{(NA-NB*WW){1'b0}}, ~col_prog_n_o}), one((NB - 1) * WW));
    wb_rst_i = 1'b1;
    #1;
    check("rst bit_sel", enc(bit_sel_o), 64'd0);
    check("rst col_prog", enc({{(NA-NB*WW){1'b0}}, ~col_prog_n_o}), 64'd0);
    check("rst preset/sense", {32'd0, preset_n_o, sense_o}, {32'd0, 16'hFFFF, 16'h0});
    check("rst rsp", {30'd0, rsp_valid_o, rsp_err_o, rsp_rdata_o}, 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check_pins("after_rst", -1, -1, 16'hFFFF, 16'h0, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, addr;
    int recent[$];
    logic [31:0] wd;

    for (int i = 0; i < NA; i++) begin
      ref_mem[i] = $urandom;
      stuck[i]   = '0;
    end
    ref_mem[3*NW + 5] = 32'hA5A5_0001;
    ref_mem[100]      = 32'h0;
    ref_mem[NA - 2]   = 32'h0;
`ifdef EFUSE_CTRL_VERIFY_EN
    stuck[NA - 2] = 32'h4;
`endif

    wb_rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; prog_en_i = 1'b1; rsp_ready_i = 1'b0;
    #1;
    check_pins("reset", -1, -1, 16'hFFFF, 16'h0, {req_ready_o, 1'b0});
    check("reset rsp", {31'd0, rsp_err_o, rsp_rdata_o}, 64'd0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("ready after reset", 64'(req_ready_o), 64'd1);

    run_txn(1'b0, 3*NW + 5, 32'h0, 1'b1, 0);
    run_txn(1'b1, 100, 32'h0000_0009, 1'b1, 0);
    run_txn(1'b0, 100, 32'h0, 1'b1, 0);
    run_txn(1'b1, 200, 32'h8000_0101, 1'b0, 0);
    run_txn(1'b1, 201, 32'h0, 1'b1, 0);
    run_txn(1'b1, 300, 32'h0000_00F0, 1'b1, 50);
    run_txn(1'b0, 300, 32'h0, 1'b1, 0);
`ifdef EFUSE_CTRL_VERIFY_EN
    run_txn(1'b1, NA - 2, 32'h6, 1'b1, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom_range(0, NA - 3);
      wd   = $urandom & $urandom & $urandom & $urandom;
      if (kind < 3) begin
        if (recent.size() > 0 && $urandom_range(0, 1) == 1)
          addr = recent[$urandom_range(0, recent.size() - 1)];
        run_txn(1'b0, addr, 32'h0, 1'b1, 0);
      end else if (kind < 8) begin
        recent.push_back(addr);
        run_txn(1'b1, addr, wd, 1'b1, 0);
      end else if (kind == 8) begin
        run_txn(1'b1, addr, wd | 32'h1, 1'b0, 0);
      end else begin
        recent.push_back(addr);
        run_txn(1'b1, addr, wd | 32'h3, 1'b1, $urandom_range(1, 2 * (PC + 2)));
      end
    end

    reset_mid_pulse();
    run_txn(1'b0, 3*NW + 5, 32'h0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
